// File: rtl/rom_dl_pkg.sv
// Shared ROM download definitions: region map, region count and download FSM states.
// Reused by the router and by any loader that needs the same address decode.
package rom_dl_pkg;

  localparam int NUM_REGIONS = 6;
  localparam int DN_ADDR_W   = 17;

  // Index 0 is the main CPU region; the map is contiguous and ascending.
  localparam logic [NUM_REGIONS-1:0][DN_ADDR_W-1:0] REGION_BASE = {
    17'h1B000, 17'h15000, 17'h0F000, 17'h0C000, 17'h0A000, 17'h00000
  };
  localparam logic [NUM_REGIONS-1:0][DN_ADDR_W-1:0] REGION_LIMIT = {
    17'h1BFFF, 17'h1AFFF, 17'h14FFF, 17'h0EFFF, 17'h0BFFF, 17'h09FFF
  };

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    DONE,
    ERROR
  } dl_state_t;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational ROM address to one-hot region decode; zero latency, no flow control.
// Addresses outside every region decode to all zeros.
module rom_region_decode
  import rom_dl_pkg::*;
(
  input  logic [DN_ADDR_W-1:0]   addr,
  output logic [NUM_REGIONS-1:0] region_hit
);

  always_comb begin
    region_hit    = '0;
    region_hit[0] = (addr <= REGION_LIMIT[0]);
    for (int i = 1; i < NUM_REGIONS; i++) begin
      region_hit[i] = (addr >= REGION_BASE[i]) && (addr <= REGION_LIMIT[i]);
    end
  end

endmodule

// File: rtl/rom_dl_router.sv
// ROM download router: decodes HPS bytes into regions, forwards them 1 cycle later, gates core reset.
// No backpressure (every in-range strobe is taken); optional running checksum under ROM_DL_CHECKSUM_EN.
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter logic [16:0] TOTAL_BYTES = 17'h1C000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [5:0]  region_we,
  output logic        rom_ready,
  output logic        core_reset,
  output logic        dl_error,
  output logic [16:0] byte_count,
  output logic [15:0] checksum
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  dl_state_t              state, state_nxt;
  logic                   dl_q;
  logic                   dl_rise, dl_fall;
  logic                   in_range, wr_req, accept, reject, len_ok;
  logic [7:0]             hold_cnt;
  logic [NUM_REGIONS-1:0] region_hit;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign in_range = (ioctl_addr < {8'd0, TOTAL_BYTES});
  assign wr_req   = (state == LOAD) & ioctl_download & ioctl_wr;
  assign accept   = wr_req & in_range;
  assign reject   = wr_req & ~in_range;
  assign len_ok   = (byte_count == TOTAL_BYTES) & ~dl_error;

  rom_region_decode u_decode (
    .addr       (ioctl_addr[16:0]),
    .region_hit (region_hit)
  );

  always_comb begin
    state_nxt = state;
    if (dl_rise) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (dl_fall) state_nxt = len_ok ? HOLD : ERROR;
        HOLD:    if (hold_cnt == 8'd0) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // dl_q captures the live download level in reset so a window that is
  // still open when reset releases never looks like a fresh rising edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      dl_q       <= ioctl_download;
      hold_cnt   <= 8'd0;
      dn_addr    <= 17'd0;
      dn_data    <= 8'd0;
      dn_wr      <= 1'b0;
      region_we  <= '0;
      byte_count <= 17'd0;
      dl_error   <= 1'b0;
      core_reset <= 1'b1;
      rom_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dl_q      <= ioctl_download;
      dn_wr     <= accept;
      region_we <= accept ? region_hit : '0;
      if (accept) begin
        dn_addr <= ioctl_addr[16:0];
        dn_data <= ioctl_dout;
      end
      if (state == LOAD) begin
        hold_cnt <= HOLD_LOAD;
      end else if (state == HOLD && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
      if (dl_rise) begin
        byte_count <= 17'd0;
        dl_error   <= 1'b0;
      end else begin
        if (accept && byte_count != 17'h1FFFF) byte_count <= byte_count + 17'd1;
        if (reject || (state == LOAD && dl_fall && !len_ok)) dl_error <= 1'b1;
      end
      core_reset <= (state_nxt != DONE);
      rom_ready  <= (state_nxt == DONE);
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= 16'd0;
    end else if (dl_rise) begin
      sum_q <= 16'd0;
    end else if (accept) begin
      sum_q <= sum_q + {8'd0, ioctl_dout};
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'd0;
`endif

endmodule
